adder_result_accumulator: RTL and testbench

//  Downstream consumer of the N-bit ripple-carry adder/mux stage. Accepts a stream of signed N-bit

---
 rtl/adder_result_accumulator.sv | 135 +++++++++++++
 tb/tb_adder_result_accumulator.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/adder_result_accumulator.sv
// Burst accumulator for the ripple-carry adder stage: sums COUNT signed samples with
// saturation, counts carry-outs, and hands the burst result out over valid/ready.
module adder_result_accumulator #(
   parameter int N      = 4,
   parameter int ACC_W  = 6,
   parameter int COUNT  = 8,
   localparam int CW    = $clog2(COUNT + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_data,
   input  logic             in_carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic [CW-1:0]    carry_cnt,
   output logic             sat_flag,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              state_r;
   state_t              state_s;
   logic [CW-1:0]       cnt_r;
   logic [ACC_W:0]      sum_s;
   logic                accept_s;
   logic                last_s;

   // One guard bit above the accumulator: differing top bits mean the sum left the signed range.
   function automatic logic is_clipped(input logic [ACC_W:0] s);
      return s[ACC_W] ^ s[ACC_W-1];
   endfunction

   function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W:0] s);
      logic [ACC_W-1:0] r;
      if (is_clipped(s)) begin
         r = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
         r = s[ACC_W-1:0];
      end
      return r;
   endfunction

   // Sample acceptance and the extended-width sum.
   always_comb begin
      accept_s = (state_r == ACCUM) && in_valid;
      last_s   = accept_s && (cnt_r == CW'(COUNT - 1));
      sum_s    = {acc_out[ACC_W-1], acc_out} + {{(ACC_W+1-N){in_data[N-1]}}, in_data};
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) state_s = ACCUM;
            else       state_s = IDLE;
         end
         ACCUM: begin
            if (last_s) state_s = DONE;
            else        state_s = ACCUM;
         end
         DONE: begin
            if (out_ready) state_s = IDLE;
            else           state_s = DONE;
         end
         default: state_s = IDLE;
      endcase
   end

   // Handshake outputs decoded from the state register only.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_r)
         IDLE: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            busy      = 1'b0;
         end
         ACCUM: begin
            in_ready  = 1'b1;
            busy      = 1'b1;
         end
         DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            busy      = 1'b0;
         end
      endcase
   end

   // Result registers: cleared on burst start, updated on each accepted sample, held otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_out   <= {ACC_W{1'b0}};
         carry_cnt <= {CW{1'b0}};
         sat_flag  <= 1'b0;
         cnt_r     <= {CW{1'b0}};
      end else if ((state_r == IDLE) && start) begin
         acc_out   <= {ACC_W{1'b0}};
         carry_cnt <= {CW{1'b0}};
         sat_flag  <= 1'b0;
         cnt_r     <= {CW{1'b0}};
      end else if (accept_s) begin
         acc_out   <= sat_acc(sum_s);
         sat_flag  <= sat_flag | is_clipped(sum_s);
         carry_cnt <= carry_cnt + CW'(in_carry);
         cnt_r     <= cnt_r + CW'(1'b1);
      end
   end

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Directed bench for adder_result_accumulator (N=4, ACC_W=6, COUNT=8).
module tb_adder_result_accumulator;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       in_carry;
   logic       out_valid;
   logic       out_ready;
   logic [5:0] acc_out;
   logic [3:0] carry_cnt;
   logic       sat_flag;
   logic       busy;

   int passed = 0;
   int total  = 0;

   adder_result_accumulator #(.N(4), .ACC_W(6), .COUNT(8)) dut (
      .clk(clk), .rst(rst), .start(start),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_carry(in_carry),
      .out_valid(out_valid), .out_ready(out_ready),
      .acc_out(acc_out), .carry_cnt(carry_cnt), .sat_flag(sat_flag), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // Two's-complement 6-bit pattern of a signed expected sum.
   function automatic logic [31:0] a6(input int v);
      logic [5:0] t;
      t = v[5:0];
      return {26'd0, t};
   endfunction

   function automatic logic [3:0] d4(input int v);
      return v[3:0];
   endfunction

   task automatic send(input int v, input logic c);
      in_valid = 1'b1;
      in_data  = d4(v);
      in_carry = c;
      tick();
      in_valid = 1'b0;
      in_carry = 1'b0;
   endtask

   task automatic begin_burst(input string tag);
      start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_busy"},    {31'd0, busy}, 32'd1);
      check({tag, "_inready"}, {31'd0, in_ready}, 32'd1);
      check({tag, "_acc_clr"}, {26'd0, acc_out}, 32'd0);
   endtask

   task automatic take_result();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      int b1 [8];
      b1 = '{3, -2, 7, -8, 1, 1, 0, -1};
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 4'd0; in_carry = 1'b0; out_ready = 1'b0;
      tick(); tick();
      check("rst_acc",   {26'd0, acc_out}, 32'd0);
      check("rst_carry", {28'd0, carry_cnt}, 32'd0);
      check("rst_sat",   {31'd0, sat_flag}, 32'd0);
      check("rst_flags", {29'd0, in_ready, out_valid, busy}, 32'd0);
      rst = 1'b0;
      tick();

      // Test 1: basic burst
      begin_burst("t1");
      for (int i = 0; i < 8; i++) begin
         if (i == 7) check("t1_not_done_early", {31'd0, out_valid}, 32'd0);
         send(b1[i], 1'b0);
      end
      check("t1_valid", {31'd0, out_valid}, 32'd1);
      check("t1_inready", {31'd0, in_ready}, 32'd0);
      check("t1_acc",   {26'd0, acc_out}, a6(1));
      check("t1_carry", {28'd0, carry_cnt}, 32'd0);
      check("t1_sat",   {31'd0, sat_flag}, 32'd0);
      take_result();
      tick();
      check("t1_idle_busy", {31'd0, busy}, 32'd0);
      check("t1_idle_hold", {26'd0, acc_out}, a6(1));

      // Test 2: positive saturation, clip at 5th sample
      begin_burst("t2");
      for (int i = 0; i < 8; i++) begin
         send(7, 1'b0);
         if (i == 3) check("t2_sat_before", {31'd0, sat_flag}, 32'd0);
         if (i == 4) check("t2_sat_at5", {31'd0, sat_flag}, 32'd1);
      end
      check("t2_acc", {26'd0, acc_out}, a6(31));
      check("t2_sat", {31'd0, sat_flag}, 32'd1);
      take_result();
      tick();

      // Test 3: negative saturation plus carries
      begin_burst("t3");
      for (int i = 0; i < 8; i++) send(-8, 1'b1);
      check("t3_acc",   {26'd0, acc_out}, a6(-32));
      check("t3_carry", {28'd0, carry_cnt}, 32'd8);
      check("t3_sat",   {31'd0, sat_flag}, 32'd1);
      take_result();
      tick();

      // Test 4: in_valid toggling and held out_ready
      begin_burst("t4");
      for (int i = 0; i < 8; i++) begin
         send(2, i[0]);
         if (i < 7) begin
            tick();
            check("t4_stall_busy", {30'd0, in_ready, out_valid}, 32'd2);
         end
      end
      check("t4_valid", {31'd0, out_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t4_hold_acc",   {26'd0, acc_out}, a6(16));
         check("t4_hold_carry", {28'd0, carry_cnt}, 32'd4);
         check("t4_hold_valid", {31'd0, out_valid}, 32'd1);
      end
      take_result();
      check("t4_idle", {30'd0, busy, out_valid}, 32'd0);

      // Test 5: reset mid-burst
      begin_burst("t5");
      for (int i = 0; i < 3; i++) send(5, 1'b1);
      check("t5_partial", {28'd0, carry_cnt}, 32'd3);
      rst = 1'b1;
      #2;
      check("t5_rst_acc",   {26'd0, acc_out}, 32'd0);
      check("t5_rst_carry", {28'd0, carry_cnt}, 32'd0);
      check("t5_rst_flags", {29'd0, in_ready, out_valid, busy}, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      begin_burst("t5b");
      for (int i = 0; i < 8; i++) send(1, 1'b0);
      check("t5_acc", {26'd0, acc_out}, a6(8));
      check("t5_sat", {31'd0, sat_flag}, 32'd0);
      take_result();
      tick();

      // Test 6: start ignored in ACCUM and DONE
      begin_burst("t6");
      for (int i = 0; i < 8; i++) begin
         start = i[0];
         send(3, i[1]);
      end
      start = 1'b1;
      tick();
      check("t6_done_hold", {31'd0, out_valid}, 32'd1);
      check("t6_acc",   {26'd0, acc_out}, a6(24));
      check("t6_carry", {28'd0, carry_cnt}, 32'd4);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t6_to_idle", {31'd0, busy}, 32'd0);
      start = 1'b0;
      tick();
      check("t6_stay_idle", {31'd0, busy}, 32'd0);
      check("t6_idle_hold", {26'd0, acc_out}, a6(24));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
